// File: rtl/ysyx_25030085_lsu.sv
// ysyx_25030085_lsu: load/store unit between EXU and the data memory port
module ysyx_25030085_lsu #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        in_we_i,
    input  logic [2:0]  in_op_i,
    input  logic [31:0] in_addr_i,
    input  logic [31:0] in_wdata_i,
    input  logic [4:0]  in_rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [4:0]  out_rd_o,
    output logic        out_wen_o,
    output logic        out_err_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wen_q, wen_d;
    logic        err_q, err_d;

    logic        accept, op_ok, align_ok;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;

    assign in_ready_o  = rst_n & (state_q == IDLE);
    assign out_valid_o = (state_q == RESP);
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;
    assign out_rdata_o = rdata_q;
    assign out_rd_o    = rd_q;
    assign out_wen_o   = wen_q;
    assign out_err_o   = err_q;

    // Request decode: legality, store lane placement and load extraction
    always_comb begin
        accept   = in_valid_i & in_ready_o;
        op_ok    = in_we_i ? (in_op_i inside {3'b000, 3'b001, 3'b010})
                           : (in_op_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        align_ok = (in_op_i[1:0] == 2'b01) ? ~in_addr_i[0] :
                   (in_op_i[1:0] == 2'b10) ? (in_addr_i[1:0] == 2'b00) : 1'b1;
        st_mask  = (in_op_i[1:0] == 2'b00) ? (4'b0001 << in_addr_i[1:0]) :
                   (in_op_i[1:0] == 2'b01) ? (in_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        st_data  = (in_op_i[1:0] == 2'b00) ? {4{in_wdata_i[7:0]}} :
                   (in_op_i[1:0] == 2'b01) ? {2{in_wdata_i[15:0]}} : in_wdata_i;
        ld_b     = mem_rdata_i[{off_q, 3'b000} +: 8];
        ld_h     = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
        ld_ext   = (op_q == 3'b000) ? {{24{ld_b[7]}}, ld_b} :
                   (op_q == 3'b001) ? {{16{ld_h[15]}}, ld_h} :
                   (op_q == 3'b010) ? mem_rdata_i :
                   (op_q == 3'b100) ? {24'b0, ld_b} :
                   (op_q == 3'b101) ? {16'b0, ld_h} : 32'b0;
    end

    // Next-state: IDLE accepts, BUSY waits for ack or timeout, RESP waits for writeback
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        op_d        = op_q;
        off_d       = off_q;
        rd_d        = rd_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        rdata_d     = rdata_q;
        wen_d       = wen_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d  = in_we_i;
                    op_d  = in_op_i;
                    off_d = in_addr_i[1:0];
                    rd_d  = in_rd_i;
                    if (op_ok && align_ok) begin
                        state_d     = BUSY;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = in_we_i;
                        mem_addr_d  = {in_addr_i[31:2], 2'b00};
                        mem_wdata_d = in_we_i ? st_data : 32'b0;
                        mem_wmask_d = in_we_i ? st_mask : 4'b0000;
                    end else begin
                        state_d = RESP;
                        rdata_d = 32'b0;
                        wen_d   = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_ack_i && mem_req_q) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    rdata_d   = we_q ? 32'b0 : ld_ext;
                    wen_d     = ~we_q & (rd_q != 5'd0);
                    err_d     = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    rdata_d   = 32'b0;
                    wen_d     = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            op_q        <= 3'b0;
            off_q       <= 2'b0;
            rd_q        <= 5'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'b0;
            mem_wdata_q <= 32'b0;
            mem_wmask_q <= 4'b0;
            rdata_q     <= 32'b0;
            wen_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            op_q        <= op_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            rdata_q     <= rdata_d;
            wen_q       <= wen_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// tb_ysyx_25030085_lsu: scoreboard bench for the load/store unit
module tb_ysyx_25030085_lsu;
    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        wen;
        logic        err;
        int          lat;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } mem_t;

    logic        clk, rst_n;
    logic        in_valid, in_ready, in_we;
    logic [2:0]  in_op;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack, resp_ack, force_ack;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_wen, out_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   rise_cyc = 0;
    int   req_cyc = 0;
    int   last_len = 0;
    int   ack_delay = 0;
    logic prev_ov = 1'b0;
    rsp_t exp_rsp[$];
    mem_t exp_mem[$];
    mem_t snap;

    ysyx_25030085_lsu #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_we_i(in_we), .in_op_i(in_op),
        .in_addr_i(in_addr), .in_wdata_i(in_wdata), .in_rd_i(in_rd),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_rdata_o(out_rdata),
        .out_rd_o(out_rd), .out_wen_o(out_wen), .out_err_o(out_err)
    );

    assign mem_ack = resp_ack | force_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: checks each new request against the scoreboard, holds it stable, acks after ack_delay
    always @(negedge clk) begin
        if (rst_n && mem_req) begin
            req_cyc++;
            if (req_cyc == 1) begin
                checks++;
                snap = '{mem_we, mem_addr, mem_wdata, mem_wmask};
                if (exp_mem.size() == 0) begin
                    errors++;
                    $display("FAIL mem_req_unexpected addr=%h we=%b", mem_addr, mem_we);
                end else begin
                    mem_t m;
                    m = exp_mem.pop_front();
                    if (mem_we !== m.we || mem_addr !== m.addr || mem_wmask !== m.mask ||
                        (m.we && mem_wdata !== m.wdata)) begin
                        errors++;
                        $display("FAIL mem_req got we=%b addr=%h wdata=%h mask=%b want we=%b addr=%h wdata=%h mask=%b",
                                 mem_we, mem_addr, mem_wdata, mem_wmask, m.we, m.addr, m.wdata, m.mask);
                    end
                end
            end else begin
                checks++;
                if (mem_we !== snap.we || mem_addr !== snap.addr || mem_wdata !== snap.wdata ||
                    mem_wmask !== snap.mask) begin
                    errors++;
                    $display("FAIL mem_stable got addr=%h mask=%b want addr=%h mask=%b",
                             mem_addr, mem_wmask, snap.addr, snap.mask);
                end
            end
        end else begin
            if (req_cyc != 0) last_len = req_cyc;
            req_cyc = 0;
        end
        resp_ack = rst_n && mem_req && ack_delay >= 0 && (req_cyc - 1 == ack_delay);
    end

    // Response monitor: pops the scoreboard on every writeback handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) rise_cyc = cyc;
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_rsp.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected rdata=%h err=%b", out_rdata, out_err);
                end else begin
                    rsp_t e;
                    e = exp_rsp.pop_front();
                    if ({out_rdata, out_rd, out_wen, out_err} !== {e.rdata, e.rd, e.wen, e.err}) begin
                        errors++;
                        $display("FAIL rsp got rdata=%h rd=%0d wen=%b err=%b want rdata=%h rd=%0d wen=%b err=%b",
                                 out_rdata, out_rd, out_wen, out_err, e.rdata, e.rd, e.wen, e.err);
                    end
                    checks++;
                    if (rise_cyc - last_acc != e.lat) begin
                        errors++;
                        $display("FAIL rsp_latency got %0d want %0d", rise_cyc - last_acc, e.lat);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic exp_r(input logic [31:0] rdata, input logic [4:0] rd, input logic wen,
                         input logic err, input int lat);
        rsp_t e;
        e = '{rdata, rd, wen, err, lat};
        exp_rsp.push_back(e);
    endtask

    task automatic exp_m(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask);
        mem_t m;
        m = '{we, addr, wdata, mask};
        exp_mem.push_back(m);
    endtask

    task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                in_we = we; in_op = op; in_addr = addr; in_wdata = wd; in_rd = rd;
                in_valid = 1'b1;
                last_acc = cyc;
                @(posedge clk);
                #1 in_valid = 1'b0;
                done = 1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL issue_timeout in_ready stayed low");
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && exp_rsp.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL wait_done %0d responses missing", exp_rsp.size());
            exp_rsp.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_we = 1'b0; in_op = 3'b0; in_addr = '0; in_wdata = '0;
        in_rd = '0; out_ready = 1'b1; force_ack = 1'b0; mem_rdata = '0; resp_ack = 1'b0;
        #1;
        chk("reset_outputs", {61'b0, in_ready, mem_req, out_valid}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {63'b0, in_ready}, 64'd1);

        mem_rdata = 32'h80FF_1234;
        exp_m(1'b0, 32'h8000_0000, 32'h0, 4'b0000);
        exp_r(32'hFFFF_FF80, 5'd5, 1'b1, 1'b0, 2);
        issue(1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd5);
        wait_done();

        exp_m(1'b1, 32'h8000_0004, 32'hBEEF_BEEF, 4'b1100);
        exp_r(32'h0, 5'd7, 1'b0, 1'b0, 2);
        issue(1'b1, 3'b001, 32'h8000_0006, 32'hDEAD_BEEF, 5'd7);
        wait_done();

        exp_r(32'h0, 5'd4, 1'b0, 1'b1, 1);
        issue(1'b0, 3'b101, 32'h0000_1001, 32'h0, 5'd4);
        wait_done();
        exp_r(32'h0, 5'd4, 1'b0, 1'b1, 1);
        issue(1'b0, 3'b010, 32'h0000_1002, 32'h0, 5'd4);
        wait_done();
        exp_r(32'h0, 5'd4, 1'b0, 1'b1, 1);
        issue(1'b0, 3'b011, 32'h0000_1000, 32'h0, 5'd4);
        wait_done();
        exp_r(32'h0, 5'd2, 1'b0, 1'b1, 1);
        issue(1'b1, 3'b100, 32'h0000_2000, 32'h1234_5678, 5'd2);
        wait_done();

        exp_m(1'b1, 32'h0000_2000, 32'h7878_7878, 4'b0010);
        exp_r(32'h0, 5'd2, 1'b0, 1'b0, 2);
        issue(1'b1, 3'b000, 32'h0000_2001, 32'h1234_5678, 5'd2);
        wait_done();

        mem_rdata = 32'h8765_4321;
        exp_m(1'b0, 32'h0000_3000, 32'h0, 4'b0000);
        exp_r(32'hFFFF_8765, 5'd3, 1'b1, 1'b0, 2);
        issue(1'b0, 3'b001, 32'h0000_3002, 32'h0, 5'd3);
        wait_done();

        exp_m(1'b1, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111);
        exp_r(32'h0, 5'd1, 1'b0, 1'b0, 2);
        issue(1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 5'd1);
        wait_done();

        ack_delay = 1;
        mem_rdata = 32'h8001_0002;
        exp_m(1'b0, 32'h0000_7000, 32'h0, 4'b0000);
        exp_r(32'h0000_8001, 5'd9, 1'b1, 1'b0, 3);
        issue(1'b0, 3'b101, 32'h0000_7002, 32'h0, 5'd9);
        wait_done();

        ack_delay = 2;
        out_ready = 1'b0;
        mem_rdata = 32'h1122_AB44;
        exp_m(1'b0, 32'h0000_3000, 32'h0, 4'b0000);
        exp_r(32'h0000_00AB, 5'd0, 1'b0, 1'b0, 4);
        issue(1'b0, 3'b100, 32'h0000_3001, 32'h0, 5'd0);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", {23'b0, out_valid, in_ready, out_rdata, out_rd, out_wen, out_err},
                {23'b0, 1'b1, 1'b0, 32'h0000_00AB, 5'd0, 1'b0, 1'b0});
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_done();

        ack_delay = -1;
        last_len = 0;
        exp_m(1'b0, 32'h0000_5000, 32'h0, 4'b0000);
        exp_r(32'h0, 5'd6, 1'b0, 1'b1, 5);
        issue(1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd6);
        wait_done();
        chk("timeout_req_len", 64'(last_len), 64'd4);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_ack_ignored", {61'b0, in_ready, out_valid, mem_req}, 64'b100);

        exp_m(1'b0, 32'h0000_6000, 32'h0, 4'b0000);
        issue(1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd8);
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_busy", {61'b0, mem_req, out_valid, in_ready}, 64'd0);
        exp_rsp.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_reset", {63'b0, in_ready}, 64'd1);
        ack_delay = 0;
        mem_rdata = 32'h0BAD_F00D;
        exp_m(1'b0, 32'h0000_6004, 32'h0, 4'b0000);
        exp_r(32'h0BAD_F00D, 5'd31, 1'b1, 1'b0, 2);
        issue(1'b0, 3'b010, 32'h0000_6004, 32'h0, 5'd31);
        wait_done();
        chk("mem_queue_drained", 64'(exp_mem.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
